// File: rtl/axi_log_pkg.sv
// Shared types, width defaults and address filter helper for the AXI log capture stage.
// The address filter (AXI_LOG_CAPTURE_FILTER_EN) uses addr_match().
package axi_log_pkg;

    localparam int unsigned AXI_ADDR_BITW_DEF = 32;
    localparam int unsigned AXI_ID_BITW_DEF   = 8;
    localparam int unsigned AXI_LEN_BITW_DEF  = 8;
    localparam int unsigned FIFO_DEPTH_DEF    = 4;
    localparam int unsigned DROP_CNT_BITW_DEF = 16;
    localparam int unsigned ADDR_MAX_W        = 64;

    typedef struct packed {
        logic                         write;
        logic [AXI_ID_BITW_DEF-1:0]   id;
        logic [AXI_ADDR_BITW_DEF-1:0] addr;
        logic [AXI_LEN_BITW_DEF-1:0]  len;
    } log_entry_t;

    function automatic logic addr_match(
        input logic [ADDR_MAX_W-1:0] addr,
        input logic [ADDR_MAX_W-1:0] base,
        input logic [ADDR_MAX_W-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/log_fifo_2w1r.sv
// Two-write / one-read FIFO; write port 0 lands before port 1 in the same cycle.
// The caller guarantees capacity for every write it asserts.
module log_fifo_2w1r #(
    parameter int unsigned DATA_W = 49,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Flush_SI,
    input  logic              Wr0En_SI,
    input  logic [DATA_W-1:0] Wr0Data_DI,
    input  logic              Wr1En_SI,
    input  logic [DATA_W-1:0] Wr1Data_DI,
    input  logic              RdEn_SI,
    output logic [DATA_W-1:0] RdData_DO,
    output logic [CNT_W-1:0]  Count_DO
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr1_slot;
    logic [CNT_W-1:0]  n_wr;

    assign wr1_slot  = Wr0En_SI ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign n_wr      = CNT_W'(Wr0En_SI) + CNT_W'(Wr1En_SI);
    assign RdData_DO = mem[rd_ptr];
    assign Count_DO  = count;

    always_ff @(posedge Clk_CI) begin
        if (Wr0En_SI) mem[wr_ptr] <= Wr0Data_DI;
        if (Wr1En_SI) mem[wr1_slot] <= Wr1Data_DI;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush_SI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_wr);
            rd_ptr <= rd_ptr + PTR_W'(RdEn_SI);
            count  <= count + n_wr - CNT_W'(RdEn_SI);
        end
    end

endmodule

// File: rtl/axi_log_capture.sv
// Snoops AXI AR/AW handshakes into a small FIFO feeding the BRAM logger; never stalls AXI.
// Optional address filter: define AXI_LOG_CAPTURE_FILTER_EN.
module axi_log_capture
    import axi_log_pkg::*;
#(
    parameter int unsigned AXI_ADDR_BITW = AXI_ADDR_BITW_DEF,
    parameter int unsigned AXI_ID_BITW   = AXI_ID_BITW_DEF,
    parameter int unsigned AXI_LEN_BITW  = AXI_LEN_BITW_DEF,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int unsigned DROP_CNT_BITW = DROP_CNT_BITW_DEF
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RBI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     Enable_SI,
    input  logic                     Clear_SI,
    input  logic                     LogFull_SI,
`ifdef AXI_LOG_CAPTURE_FILTER_EN
    input  logic [AXI_ADDR_BITW-1:0] FiltBase_DI,
    input  logic [AXI_ADDR_BITW-1:0] FiltMask_DI,
`endif
    output logic                     LogValid_SO,
    output logic                     LogWrite_SO,
    output logic [AXI_ID_BITW-1:0]   LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic [DROP_CNT_BITW-1:0] DropCnt_DO,
    output logic                     Overflow_SO
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DATA_W = 1 + AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;

    typedef struct packed {
        logic                     write;
        logic [AXI_ID_BITW-1:0]   id;
        logic [AXI_ADDR_BITW-1:0] addr;
        logic [AXI_LEN_BITW-1:0]  len;
    } entry_t;

    entry_t             ar_entry;
    entry_t             aw_entry;
    entry_t             head;
    logic [DATA_W-1:0]  rd_data;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     free;
    logic               empty;
    logic               pop;
    logic               ar_keep;
    logic               aw_keep;
    logic               cap_ar;
    logic               cap_aw;
    logic               acc_ar;
    logic               acc_aw;
    logic               wr0_en;
    logic               wr1_en;
    entry_t             wr0_data;
    logic [1:0]         n_drop;
    logic [DROP_CNT_BITW:0] drop_sum;
    logic [DROP_CNT_BITW-1:0] drop_cnt;
    logic               overflow;

`ifdef AXI_LOG_CAPTURE_FILTER_EN
    assign ar_keep = addr_match(ADDR_MAX_W'(ArAddr_DI),
                                ADDR_MAX_W'(FiltBase_DI),
                                ADDR_MAX_W'(FiltMask_DI));
    assign aw_keep = addr_match(ADDR_MAX_W'(AwAddr_DI),
                                ADDR_MAX_W'(FiltBase_DI),
                                ADDR_MAX_W'(FiltMask_DI));
`else
    assign ar_keep = 1'b1;
    assign aw_keep = 1'b1;
`endif

    assign ar_entry = '{write: 1'b0, id: ArId_DI, addr: ArAddr_DI, len: ArLen_DI};
    assign aw_entry = '{write: 1'b1, id: AwId_DI, addr: AwAddr_DI, len: AwLen_DI};

    assign cap_ar = ArValid_SI & ArReady_SI & Enable_SI & ~Clear_SI & ar_keep;
    assign cap_aw = AwValid_SI & AwReady_SI & Enable_SI & ~Clear_SI & aw_keep;

    assign empty = (count == '0);
    assign pop   = ~empty & ~LogFull_SI & ~Clear_SI;

    // A same-cycle pop frees a slot for this cycle's captures.
    assign free = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, count} + (CNT_W+1)'(pop);

    assign acc_ar = cap_ar & (free >= (CNT_W+1)'(1));
    assign acc_aw = cap_aw & (free >= (acc_ar ? (CNT_W+1)'(2) : (CNT_W+1)'(1)));

    assign wr0_en   = acc_ar | acc_aw;
    assign wr0_data = acc_ar ? ar_entry : aw_entry;
    assign wr1_en   = acc_ar & acc_aw;

    assign n_drop   = {1'b0, cap_ar & ~acc_ar} + {1'b0, cap_aw & ~acc_aw};
    assign drop_sum = {1'b0, drop_cnt} + (DROP_CNT_BITW+1)'(n_drop);

    log_fifo_2w1r #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk_CI     (Clk_CI),
        .Rst_RBI    (Rst_RBI),
        .Flush_SI   (Clear_SI),
        .Wr0En_SI   (wr0_en),
        .Wr0Data_DI (wr0_data),
        .Wr1En_SI   (wr1_en),
        .Wr1Data_DI (aw_entry),
        .RdEn_SI    (pop),
        .RdData_DO  (rd_data),
        .Count_DO   (count)
    );

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (Clear_SI) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (n_drop != 2'd0) begin
            drop_cnt <= drop_sum[DROP_CNT_BITW] ? '1 : drop_sum[DROP_CNT_BITW-1:0];
            overflow <= 1'b1;
        end
    end

    // Masking with empty keeps outputs at zero out of reset (storage is not reset).
    assign head        = empty ? '0 : entry_t'(rd_data);
    assign LogValid_SO = pop;
    assign LogWrite_SO = head.write;
    assign LogId_DO    = head.id;
    assign LogAddr_DO  = head.addr;
    assign LogLen_DO   = head.len;
    assign DropCnt_DO  = drop_cnt;
    assign Overflow_SO = overflow;

endmodule

// File: tb/tb_axi_log_capture.sv
// Scoreboard bench for axi_log_capture: randomized and directed snoop traffic
// against a queue-level reference model.
module tb_axi_log_capture;

    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int LW  = 8;
    localparam int D   = 4;
    localparam int DCW = 4;
    localparam int DMAX = (1 << DCW) - 1;

    typedef logic [IW+AW+LW:0] ent_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          ar_v = 0, ar_r = 0, aw_v = 0, aw_r = 0;
    logic [IW-1:0] ar_id = 0, aw_id = 0;
    logic [AW-1:0] ar_addr = 0, aw_addr = 0;
    logic [LW-1:0] ar_len = 0, aw_len = 0;
    logic          en = 1, clr = 0, full = 0;
    logic [AW-1:0] f_base = 32'h4000_0000;
    logic [AW-1:0] f_mask = 32'hF000_0000;
    logic          lv, lw;
    logic [IW-1:0] lid;
    logic [AW-1:0] laddr;
    logic [LW-1:0] llen;
    logic [DCW-1:0] dcnt;
    logic          ovf;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t mq[$];
    ent_t sb[$];
    int   mdrop = 0;
    bit   movf = 0;
    bit   exp_valid = 0;
    bit   mon_en = 0;

    always #5 clk = ~clk;

    axi_log_capture #(
        .AXI_ADDR_BITW (AW),
        .AXI_ID_BITW   (IW),
        .AXI_LEN_BITW  (LW),
        .FIFO_DEPTH    (D),
        .DROP_CNT_BITW (DCW)
    ) dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .ArValid_SI  (ar_v),
        .ArReady_SI  (ar_r),
        .ArId_DI     (ar_id),
        .ArAddr_DI   (ar_addr),
        .ArLen_DI    (ar_len),
        .AwValid_SI  (aw_v),
        .AwReady_SI  (aw_r),
        .AwId_DI     (aw_id),
        .AwAddr_DI   (aw_addr),
        .AwLen_DI    (aw_len),
        .Enable_SI   (en),
        .Clear_SI    (clr),
        .LogFull_SI  (full),
`ifdef AXI_LOG_CAPTURE_FILTER_EN
        .FiltBase_DI (f_base),
        .FiltMask_DI (f_mask),
`endif
        .LogValid_SO (lv),
        .LogWrite_SO (lw),
        .LogId_DO    (lid),
        .LogAddr_DO  (laddr),
        .LogLen_DO   (llen),
        .DropCnt_DO  (dcnt),
        .Overflow_SO (ovf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit keep(input logic [AW-1:0] a);
`ifdef AXI_LOG_CAPTURE_FILTER_EN
        return (a & f_mask) == (f_base & f_mask);
`else
        return 1'b1;
`endif
    endfunction

    // One clock of stimulus: inputs are already driven; model the cycle, then let the edge pass.
    task automatic step();
        int nd = 0;
        exp_valid = !clr && mq.size() > 0 && !full;
        if (exp_valid) sb.push_back(mq.pop_front());
        if (clr) begin
            mq.delete();
            mdrop = 0;
            movf = 0;
        end else begin
            if (ar_v && ar_r && en && keep(ar_addr)) begin
                if (mq.size() < D) mq.push_back({1'b0, ar_id, ar_addr, ar_len});
                else nd++;
            end
            if (aw_v && aw_r && en && keep(aw_addr)) begin
                if (mq.size() < D) mq.push_back({1'b1, aw_id, aw_addr, aw_len});
                else nd++;
            end
            mdrop = (mdrop + nd > DMAX) ? DMAX : mdrop + nd;
            if (nd > 0) movf = 1;
        end
        @(posedge clk);
        #1;
        chk("drop_cnt", 64'(dcnt), 64'(mdrop));
        chk("overflow", 64'(ovf), 64'(movf));
    endtask

    task automatic idle(input int n);
        ar_v = 0; aw_v = 0; clr = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ar(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        ar_v = 1; ar_r = 1; ar_id = id; ar_addr = a; ar_len = l;
    endtask

    task automatic set_aw(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [LW-1:0] l);
        aw_v = 1; aw_r = 1; aw_id = id; aw_addr = a; aw_len = l;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a = AW'($urandom);
`ifdef AXI_LOG_CAPTURE_FILTER_EN
        a[AW-1:AW-4] = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'h5;
`endif
        return a;
    endfunction

    // Monitor: compares valid each cycle and pops the scoreboard on every presented entry.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            chk("log_valid", 64'(lv), 64'(exp_valid));
            if (lv === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_entry", 64'(1), 64'(0));
                else chk("entry", 64'({lw, lid, laddr, llen}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #23;
        chk("rst_valid", 64'(lv), 0);
        chk("rst_data", 64'({lw, lid, laddr, llen}), 0);
        chk("rst_drop", 64'(dcnt), 0);
        chk("rst_ovf", 64'(ovf), 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // single AR
        set_ar(8'h3, 32'h1000_0040, 8'd7);
        step();
        idle(3);

        // AR and AW together
        set_ar(8'h11, 32'h0000_00A0, 8'd1);
        set_aw(8'h22, 32'h0000_00B0, 8'd2);
        step();
        idle(4);

        // logger full: fill then overflow
        full = 1;
        for (int i = 0; i < 6; i++) begin
            set_ar(8'(i), 32'h100 + 32'(i * 16), 8'(i));
            step();
        end
        chk("full_drops", 64'(dcnt), 64'd2);
        chk("full_ovf", 64'(ovf), 64'd1);
        full = 0;
        idle(6);

        // sustained dual capture saturates the narrow counter
        for (int i = 0; i < 20; i++) begin
            set_ar(8'(i), 32'h2000 + 32'(i), 8'd0);
            set_aw(8'(i + 64), 32'h3000 + 32'(i), 8'd1);
            step();
        end
        chk("sat_drops", 64'(dcnt), 64'(DMAX));
        idle(6);

        // clear with entries queued and a capture in the same cycle
        full = 1;
        for (int i = 0; i < 3; i++) begin
            set_ar(8'(i), 32'h500 + 32'(i), 8'd3);
            step();
        end
        full = 0;
        set_ar(8'h77, 32'h600, 8'd4);
        clr = 1;
        step();
        chk("clr_drops", 64'(dcnt), 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        idle(3);

`ifdef AXI_LOG_CAPTURE_FILTER_EN
        set_ar(8'h1, 32'h4000_0010, 8'd0);
        step();
        set_ar(8'h2, 32'h5000_0010, 8'd0);
        step();
        idle(3);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ar_v = ($urandom_range(0, 3) != 0);
            ar_r = ($urandom_range(0, 3) != 0);
            aw_v = ($urandom_range(0, 3) != 0);
            aw_r = ($urandom_range(0, 3) != 0);
            ar_id = IW'($urandom);
            aw_id = IW'($urandom);
            ar_addr = rnd_addr();
            aw_addr = rnd_addr();
            ar_len = LW'($urandom);
            aw_len = LW'($urandom);
            en = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) full = ~full;
            step();
        end
        full = 0;
        en = 1;
        idle(D + 4);
        chk("sb_drained", 64'(sb.size()), 0);
        chk("model_drained", 64'(mq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
